// File: rtl/fadd_issue_arbiter.sv
// Round-robin issue of two requesters into one shared pipelined FP adder, with a
// sideband src/tag pipeline kept in lock-step with the adder and result backpressure.
module fadd_issue_arbiter #(
    parameter int LAT  = 3,
    parameter int TAGW = 5,
    parameter int SCW  = 16
) (
    input  logic                     clk,
    input  logic                     clrn,
    input  logic                     r0_valid,
    output logic                     r0_ready,
    input  logic [31:0]              r0_a,
    input  logic [31:0]              r0_b,
    input  logic                     r0_sub,
    input  logic [1:0]               r0_rm,
    input  logic [TAGW-1:0]          r0_tag,
    input  logic                     r1_valid,
    output logic                     r1_ready,
    input  logic [31:0]              r1_a,
    input  logic [31:0]              r1_b,
    input  logic                     r1_sub,
    input  logic [1:0]               r1_rm,
    input  logic [TAGW-1:0]          r1_tag,
    output logic [31:0]              fa_a,
    output logic [31:0]              fa_b,
    output logic                     fa_sub,
    output logic [1:0]               fa_rm,
    output logic                     fa_e,
    input  logic [31:0]              fa_s,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     res_src,
    output logic [TAGW-1:0]          res_tag,
    output logic [31:0]              res_data,
    output logic [$clog2(LAT+1)-1:0] inflight,
    output logic [SCW-1:0]           stall_cnt
);
    localparam int IFW = $clog2(LAT+1);

    logic [LAT-1:0]  vld_r;
    logic [LAT-1:0]  src_r;
    logic [TAGW-1:0] tag_r [LAT];
    logic            rr_ptr_r;
    logic [IFW-1:0]  inflight_r;
    logic [SCW-1:0]  stall_cnt_r;

    logic            stall_s;
    logic            gnt0_s;
    logic            gnt1_s;
    logic            issue_s;
    logic            done_s;
    logic            gnt_src_s;
    logic [TAGW-1:0] gnt_tag_s;

    assign stall_s   = vld_r[LAT-1] & ~res_ready;
    assign fa_e      = clrn & ~stall_s;
    assign issue_s   = gnt0_s | gnt1_s;
    assign done_s    = vld_r[LAT-1] & res_ready;

    assign r0_ready  = gnt0_s;
    assign r1_ready  = gnt1_s;
    assign res_valid = vld_r[LAT-1];
    assign res_src   = src_r[LAT-1];
    assign res_tag   = tag_r[LAT-1];
    assign res_data  = fa_s;
    assign inflight  = inflight_r;
    assign stall_cnt = stall_cnt_r;

    // Grant: a lone requester always wins, rr_ptr only breaks ties
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (fa_e) begin
            if (r0_valid && r1_valid) begin
                gnt0_s = ~rr_ptr_r;
                gnt1_s = rr_ptr_r;
            end else begin
                gnt0_s = r0_valid;
                gnt1_s = r1_valid;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Operand and sideband mux from the granted requester, zero when idle
    always_comb begin
        fa_a      = 32'h0000_0000;
        fa_b      = 32'h0000_0000;
        fa_sub    = 1'b0;
        fa_rm     = 2'b00;
        gnt_src_s = 1'b0;
        gnt_tag_s = {TAGW{1'b0}};
        if (gnt0_s) begin
            fa_a      = r0_a;
            fa_b      = r0_b;
            fa_sub    = r0_sub;
            fa_rm     = r0_rm;
            gnt_tag_s = r0_tag;
        end else if (gnt1_s) begin
            fa_a      = r1_a;
            fa_b      = r1_b;
            fa_sub    = r1_sub;
            fa_rm     = r1_rm;
            gnt_src_s = 1'b1;
            gnt_tag_s = r1_tag;
        end else begin
            fa_a      = 32'h0000_0000;
            fa_b      = 32'h0000_0000;
        end
    end

    // Sideband pipeline, round-robin pointer, occupancy and stall counters
    always_ff @(posedge clk) begin
        if (!clrn) begin
            vld_r       <= {LAT{1'b0}};
            src_r       <= {LAT{1'b0}};
            rr_ptr_r    <= 1'b0;
            inflight_r  <= {IFW{1'b0}};
            stall_cnt_r <= {SCW{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                tag_r[i] <= {TAGW{1'b0}};
            end
        end else begin
            // Empty slots shift too, so the tags stay aligned with the adder stages
            if (fa_e) begin
                for (int i = LAT-1; i > 0; i--) begin
                    vld_r[i] <= vld_r[i-1];
                    src_r[i] <= src_r[i-1];
                    tag_r[i] <= tag_r[i-1];
                end
                vld_r[0] <= issue_s;
                src_r[0] <= gnt_src_s;
                tag_r[0] <= gnt_tag_s;
            end
            if (issue_s && r0_valid && r1_valid) begin
                rr_ptr_r <= ~rr_ptr_r;
            end
            case ({issue_s, done_s})
                2'b10:   inflight_r <= inflight_r + IFW'(1'b1);
                2'b01:   inflight_r <= inflight_r - IFW'(1'b1);
                default: inflight_r <= inflight_r;
            endcase
            if (stall_s && (stall_cnt_r != {SCW{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + SCW'(1'b1);
            end
        end
    end
endmodule

// File: tb/tb_fadd_issue_arbiter.sv
// Directed bench for fadd_issue_arbiter with a behavioural 3-stage adder and a
// result scoreboard of {src, tag, data} in issue order.
module tb_fadd_issue_arbiter;
    localparam int LAT  = 3;
    localparam int TAGW = 5;
    localparam int SCW  = 4;

    logic            clk;
    logic            clrn;
    logic            r0_valid, r0_ready, r0_sub;
    logic [31:0]     r0_a, r0_b;
    logic [1:0]      r0_rm;
    logic [TAGW-1:0] r0_tag;
    logic            r1_valid, r1_ready, r1_sub;
    logic [31:0]     r1_a, r1_b;
    logic [1:0]      r1_rm;
    logic [TAGW-1:0] r1_tag;
    logic [31:0]     fa_a, fa_b, fa_s;
    logic            fa_sub, fa_e;
    logic [1:0]      fa_rm;
    logic            res_valid, res_ready, res_src;
    logic [TAGW-1:0] res_tag;
    logic [31:0]     res_data;
    logic [1:0]      inflight;
    logic [SCW-1:0]  stall_cnt;

    logic [31:0]     pipe [LAT];
    logic [37:0]     exp_q [$];
    int              total = 0;
    int              passed = 0;
    int              i0, i1;

    fadd_issue_arbiter #(.LAT(LAT), .TAGW(TAGW), .SCW(SCW)) dut (
        .clk(clk), .clrn(clrn),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b),
        .r0_sub(r0_sub), .r0_rm(r0_rm), .r0_tag(r0_tag),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b),
        .r1_sub(r1_sub), .r1_rm(r1_rm), .r1_tag(r1_tag),
        .fa_a(fa_a), .fa_b(fa_b), .fa_sub(fa_sub), .fa_rm(fa_rm), .fa_e(fa_e), .fa_s(fa_s),
        .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
        .res_tag(res_tag), .res_data(res_data), .inflight(inflight), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Known FP sums from the test plan; anything else is integer add/sub
    function automatic logic [31:0] fmodel(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (a == 32'h3f800000 && b == 32'h40000000 && !s) return 32'h40400000;
        if (a == 32'h40400000 && b == 32'h3f800000 && s)  return 32'h40000000;
        if (a == 32'h3f800000 && b == 32'h3f800000 && !s) return 32'h40000000;
        return s ? (a - b) : (a + b);
    endfunction

    // Behavioural pipelined adder that holds while e is low
    always @(posedge clk) begin
        if (fa_e) begin
            for (int i = LAT-1; i > 0; i--) pipe[i] <= pipe[i-1];
            pipe[0] <= fmodel(fa_a, fa_b, fa_sub);
        end
    end
    assign fa_s = pipe[LAT-1];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", name, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Check the result port against the scoreboard, then the grants, then clock once
    task automatic step(input logic er0, input logic er1, input logic [31:0] e0, input logic [31:0] e1);
        if (exp_q.size() == 0) begin
            chk("res_idle", 32'(res_valid), 32'h0);
        end else if (res_valid) begin
            chk("res_data", res_data, exp_q[0][31:0]);
            chk("res_src", 32'(res_src), 32'(exp_q[0][37]));
            chk("res_tag", 32'(res_tag), 32'(exp_q[0][36:32]));
            if (res_ready) void'(exp_q.pop_front());
        end
        #1;
        chk("r0_ready", 32'(r0_ready), 32'(er0));
        chk("r1_ready", 32'(r1_ready), 32'(er1));
        if (r0_ready) exp_q.push_back({1'b0, r0_tag, e0});
        if (r1_ready) exp_q.push_back({1'b1, r1_tag, e1});
        tick();
    endtask

    initial begin
        clrn = 1'b0; res_ready = 1'b1;
        r0_valid = 1'b1; r0_a = 32'h3f800000; r0_b = 32'h40000000; r0_sub = 1'b0; r0_rm = 2'd0; r0_tag = 5'd5;
        r1_valid = 1'b0; r1_a = 32'h0; r1_b = 32'h0; r1_sub = 1'b0; r1_rm = 2'd0; r1_tag = 5'd0;

        // Reset for two edges with a request pending
        tick(); tick();
        chk("rst_r0_ready", 32'(r0_ready), 32'h0);
        chk("rst_fa_e", 32'(fa_e), 32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_inflight", 32'(inflight), 32'h0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);

        // Single op: result exactly LAT edges after issue
        clrn = 1'b1;
        #1;
        chk("s_r0_ready", 32'(r0_ready), 32'h1);
        chk("s_r1_ready", 32'(r1_ready), 32'h0);
        chk("s_fa_a", fa_a, 32'h3f800000);
        chk("s_fa_b", fa_b, 32'h40000000);
        chk("s_fa_sub", 32'(fa_sub), 32'h0);
        chk("s_fa_e", 32'(fa_e), 32'h1);
        tick();
        r0_valid = 1'b0;
        #1;
        chk("s_ready_drop", 32'(r0_ready), 32'h0);
        chk("s_idle_fa_a", fa_a, 32'h0);
        chk("s_inflight1", 32'(inflight), 32'h1);
        tick();
        chk("s_early", 32'(res_valid), 32'h0);
        tick();
        chk("s_res_valid", 32'(res_valid), 32'h1);
        chk("s_res_data", res_data, 32'h40400000);
        chk("s_res_src", 32'(res_src), 32'h0);
        chk("s_res_tag", 32'(res_tag), 32'h5);
        chk("s_inflight_hold", 32'(inflight), 32'h1);
        tick();
        chk("s_res_gone", 32'(res_valid), 32'h0);
        chk("s_inflight0", 32'(inflight), 32'h0);

        // Contention: both valid, grants alternate starting with r0
        i0 = 0; i1 = 0;
        r0_a = 32'h40400000; r0_b = 32'h3f800000; r0_sub = 1'b1;
        r1_a = 32'h3f800000; r1_b = 32'h3f800000; r1_sub = 1'b0;
        for (int k = 0; k < 8; k++) begin
            r0_valid = (i0 < 4); r0_tag = 5'(i0);
            r1_valid = (i1 < 4); r1_tag = 5'(16 + i1);
            if (k == 0) begin
                #1;
                chk("c_fa_sub", 32'(fa_sub), 32'h1);
                chk("c_fa_a", fa_a, 32'h40400000);
            end
            step(k % 2 == 0, k % 2 == 1, 32'h40000000, 32'h40000000);
            if (k % 2 == 0) i0++; else i1++;
        end
        r0_valid = 1'b0; r1_valid = 1'b0;
        repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("c_drained", 32'(exp_q.size()), 32'h0);

        // Idle requester: r1 alone, then a tie which r1 must win (rr_ptr left at 1)
        for (int j = 0; j < 3; j++) begin
            r1_valid = 1'b1; r1_a = 32'h10 + 32'(j); r1_b = 32'h0; r1_tag = 5'(7 + j);
            step(1'b0, 1'b1, 32'h0, 32'h10 + 32'(j));
        end
        r0_valid = 1'b1; r0_a = 32'h30; r0_b = 32'h0; r0_sub = 1'b0; r0_tag = 5'd10;
        r1_a = 32'h13; r1_tag = 5'd11;
        step(1'b0, 1'b1, 32'h30, 32'h13);
        r1_valid = 1'b0;
        step(1'b1, 1'b0, 32'h30, 32'h0);
        r0_valid = 1'b0;
        repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("i_drained", 32'(exp_q.size()), 32'h0);

        // Backpressure: fill, stall four cycles, then drain in order
        for (int j = 0; j < 3; j++) begin
            r0_valid = 1'b1; r0_a = 32'h20 + 32'(j); r0_tag = 5'(1 + j);
            step(1'b1, 1'b0, 32'h20 + 32'(j), 32'h0);
        end
        chk("b_inflight_full", 32'(inflight), 32'h3);
        chk("b_stall_cnt0", 32'(stall_cnt), 32'h0);
        res_ready = 1'b0;
        r0_a = 32'h23; r0_tag = 5'd4;
        repeat (4) begin
            #1;
            chk("b_fa_e", 32'(fa_e), 32'h0);
            chk("b_inflight", 32'(inflight), 32'h3);
            step(1'b0, 1'b0, 32'h23, 32'h0);
        end
        chk("b_stall_cnt4", 32'(stall_cnt), 32'h4);
        res_ready = 1'b1;
        step(1'b1, 1'b0, 32'h23, 32'h0);
        r0_valid = 1'b0;
        repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("b_drained", 32'(exp_q.size()), 32'h0);

        // Reset with two ops in flight: they are discarded
        for (int j = 0; j < 2; j++) begin
            r0_valid = 1'b1; r0_a = 32'h40 + 32'(j); r0_tag = 5'(12 + j);
            step(1'b1, 1'b0, 32'h40 + 32'(j), 32'h0);
        end
        chk("r_inflight2", 32'(inflight), 32'h2);
        clrn = 1'b0;
        #1;
        chk("r_ready_in_rst", 32'(r0_ready), 32'h0);
        chk("r_fa_e_in_rst", 32'(fa_e), 32'h0);
        tick();
        chk("r_res_valid", 32'(res_valid), 32'h0);
        chk("r_inflight", 32'(inflight), 32'h0);
        chk("r_stall_cnt", 32'(stall_cnt), 32'h0);
        exp_q.delete();
        clrn = 1'b1; r0_valid = 1'b0;
        repeat (4) step(1'b0, 1'b0, 32'h0, 32'h0);
        r0_valid = 1'b1; r0_a = 32'h3f800000; r0_b = 32'h40000000; r0_tag = 5'd5;
        step(1'b1, 1'b0, 32'h40400000, 32'h0);
        r0_valid = 1'b0;
        tick();
        chk("r_lat_early", 32'(res_valid), 32'h0);
        tick();
        chk("r_lat_valid", 32'(res_valid), 32'h1);
        chk("r_lat_data", res_data, 32'h40400000);
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("r_drained", 32'(exp_q.size()), 32'h0);

        // Stall counter saturation with a 4-bit counter
        r0_valid = 1'b1; r0_a = 32'h50; r0_b = 32'h0; r0_tag = 5'd20;
        step(1'b1, 1'b0, 32'h50, 32'h0);
        r0_valid = 1'b0;
        repeat (2) step(1'b0, 1'b0, 32'h0, 32'h0);
        res_ready = 1'b0;
        repeat (20) step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("sat_stall_cnt", 32'(stall_cnt), 32'hf);
        res_ready = 1'b1;
        step(1'b0, 1'b0, 32'h0, 32'h0);
        chk("sat_drained", 32'(exp_q.size()), 32'h0);
        chk("sat_inflight", 32'(inflight), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
